// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the memory-stage load/store engine: access sizes,
// FSM states and the alignment rule used by both the top and the lane formatter.
package mem_access_unit_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        DONE = 2'b11
    } mau_state_t;

    // Bytes are always aligned; halves need addr[0]=0; words (and the
    // reserved size, which behaves as a word) need addr[1:0]=0.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        logic mis;
        case (size)
            SIZE_B:  mis = 1'b0;
            SIZE_H:  mis = addr_lo[0];
            default: mis = |addr_lo;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Byte-lane formatter: strobes and replicated store data for the outgoing
// request, and lane selection plus sign/zero extension for returned loads.
// Purely combinational so the cache path can share it.
module mem_lane_fmt
    import mem_access_unit_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sgn,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata_in,
    input  logic [31:0] rdata_in,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_out,
    output logic [31:0] rdata_out
);

    logic [31:0] shifted;

    // Store side: strobes follow the addressed lanes, data fills every lane
    always_comb begin
        wstrb     = 4'b1111;
        wdata_out = wdata_in;
        case (size)
            SIZE_B: begin
                wstrb     = 4'b0001 << addr_lo;
                wdata_out = {4{wdata_in[7:0]}};
            end
            SIZE_H: begin
                wstrb     = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_out = {2{wdata_in[15:0]}};
            end
            default: begin
                wstrb     = 4'b1111;
                wdata_out = wdata_in;
            end
        endcase
    end

    // Load side: move the addressed lane down to bit 0, then extend
    always_comb begin
        shifted   = rdata_in >> {addr_lo, 3'b000};
        rdata_out = rdata_in;
        case (size)
            SIZE_B:  rdata_out = {{24{sgn & shifted[7]}}, shifted[7:0]};
            SIZE_H:  rdata_out = {{16{sgn & shifted[15]}}, shifted[15:0]};
            default: rdata_out = rdata_in;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store engine. Turns one M-stage memory op into a
// req/gnt/rvalid bus transaction, stalls the pipeline until it completes,
// and returns the extended load result. A timeout aborts a hung access.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memenM,
    input  logic        memwriteM,
    input  logic [1:0]  sizeM,
    input  logic        signedM,
    input  logic [31:0] addrM,
    input  logic [31:0] writedataM,
    input  logic        stall_ext,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    output logic [31:0] readdataM,
    output logic        stall_mem,
    output logic        adel,
    output logic        ades,
    output logic        bus_err
);

    mau_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       lat_size;
    logic             lat_signed;
    logic [1:0]       lat_lo;

    logic             misaligned;
    logic             start;
    logic             timeout;

    logic [1:0]       fmt_size;
    logic [1:0]       fmt_lo;
    logic [3:0]       fmt_wstrb;
    logic [31:0]      fmt_wdata;
    logic [31:0]      fmt_rdata;

    assign misaligned = is_misaligned(sizeM, addrM[1:0]);
    assign adel       = memenM & ~memwriteM & misaligned;
    assign ades       = memenM &  memwriteM & misaligned;
    assign start      = (state == IDLE) & memenM & ~misaligned;
    assign stall_mem  = start | (state == REQ) | (state == WAIT);

    // The counter is checked one short of the limit so that the access is
    // given exactly TIMEOUT_CYC cycles in REQ+WAIT before it is aborted.
    assign timeout    = (cnt == CNT_W'(TIMEOUT_CYC - 1));

    // In IDLE the formatter serves the incoming op's store lanes; afterwards
    // it serves the latched op's load extraction.
    assign fmt_size   = (state == IDLE) ? sizeM       : lat_size;
    assign fmt_lo     = (state == IDLE) ? addrM[1:0]  : lat_lo;

    mem_lane_fmt u_fmt (
        .size      (fmt_size),
        .sgn       (lat_signed),
        .addr_lo   (fmt_lo),
        .wdata_in  (writedataM),
        .rdata_in  (bus_rdata),
        .wstrb     (fmt_wstrb),
        .wdata_out (fmt_wdata),
        .rdata_out (fmt_rdata)
    );

    // Access FSM with registered bus outputs, timeout counter and load result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            lat_size   <= SIZE_W;
            lat_signed <= 1'b0;
            lat_lo     <= 2'b00;
            bus_req    <= 1'b0;
            bus_wr     <= 1'b0;
            bus_addr   <= '0;
            bus_wstrb  <= '0;
            bus_wdata  <= '0;
            readdataM  <= '0;
            bus_err    <= 1'b0;
        end else begin
            bus_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= REQ;
                        cnt        <= '0;
                        bus_req    <= 1'b1;
                        bus_wr     <= memwriteM;
                        bus_addr   <= {addrM[31:2], 2'b00};
                        bus_wstrb  <= fmt_wstrb;
                        bus_wdata  <= fmt_wdata;
                        lat_size   <= sizeM;
                        lat_signed <= signedM;
                        lat_lo     <= addrM[1:0];
                    end
                end
                REQ: begin
                    if (bus_gnt && bus_rvalid) begin
                        state   <= DONE;
                        bus_req <= 1'b0;
                        if (!bus_wr) begin
                            readdataM <= fmt_rdata;
                        end
                    end else if (timeout) begin
                        state     <= DONE;
                        bus_req   <= 1'b0;
                        bus_err   <= 1'b1;
                        readdataM <= '0;
                        cnt       <= cnt + 1'b1;
                    end else if (bus_gnt) begin
                        state   <= WAIT;
                        bus_req <= 1'b0;
                        cnt     <= cnt + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (bus_rvalid) begin
                        state <= DONE;
                        if (!bus_wr) begin
                            readdataM <= fmt_rdata;
                        end
                    end else if (timeout) begin
                        state     <= DONE;
                        bus_err   <= 1'b1;
                        readdataM <= '0;
                        cnt       <= cnt + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    // Holding here while stall_ext is high keeps the still-present
                    // op from being issued a second time.
                    if (!stall_ext) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: table of load/store transactions with a
// scripted bus responder and a readdata scoreboard, plus hand sequences for
// misalignment, timeout, external stall and reset during an access.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        memenM, memwriteM, signedM, stall_ext;
    logic [1:0]  sizeM;
    logic [31:0] addrM, writedataM;
    logic        bus_req, bus_wr, bus_gnt, bus_rvalid;
    logic [31:0] bus_addr, bus_wdata, bus_rdata, readdataM;
    logic [3:0]  bus_wstrb;
    logic        stall_mem, adel, ades, bus_err;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [31:0] exp_baddr;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rd;
        int          gnt_lat;
        int          rv_lat;
    } vec_t;

    vec_t        vecs[10];
    logic [31:0] exp_q[$];
    logic [31:0] last_rd;

    mem_access_unit #(.TIMEOUT_CYC(4), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .memenM     (memenM),
        .memwriteM  (memwriteM),
        .sizeM      (sizeM),
        .signedM    (signedM),
        .addrM      (addrM),
        .writedataM (writedataM),
        .stall_ext  (stall_ext),
        .bus_req    (bus_req),
        .bus_wr     (bus_wr),
        .bus_addr   (bus_addr),
        .bus_wstrb  (bus_wstrb),
        .bus_wdata  (bus_wdata),
        .bus_gnt    (bus_gnt),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata),
        .readdataM  (readdataM),
        .stall_mem  (stall_mem),
        .adel       (adel),
        .ades       (ades),
        .bus_err    (bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic [1:0] size, input logic sgn,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input logic [31:0] baddr,
                                input logic [3:0] wstrb, input logic [31:0] ewdata,
                                input logic [31:0] erd, input int gl, input int rl);
        vec_t v;
        v.wr = wr; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
        v.rdata = rdata; v.exp_baddr = baddr; v.exp_wstrb = wstrb;
        v.exp_wdata = ewdata; v.exp_rd = erd; v.gnt_lat = gl; v.rv_lat = rl;
        return v;
    endfunction

    // Issue one op and act as the bus slave: grant after gnt_lat REQ cycles,
    // respond rv_lat cycles after the grant (0 = same cycle as grant).
    task automatic run_op(input vec_t v, input logic [31:0] exp_rd,
                          output int stall_cnt, output int req_cnt, output int err_cnt);
        int  gcount;
        int  since;
        bit  granted;
        bit  done;
        logic [31:0] e;
        gcount = 0; since = 0; granted = 0; done = 0;
        stall_cnt = 0; req_cnt = 0; err_cnt = 0;
        @(negedge clk);
        memenM = 1'b1; memwriteM = v.wr; sizeM = v.size; signedM = v.sgn;
        addrM = v.addr; writedataM = v.wdata;
        exp_q.push_back(exp_rd);
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            #1;
            if (bus_err) err_cnt++;
            if (cyc > 0 && !stall_mem) begin
                done = 1;
            end else begin
                if (stall_mem) stall_cnt++;
                bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'hBAD0BAD0;
                if (bus_req) begin
                    req_cnt++;
                    if (req_cnt == 1) begin
                        chk("bus_addr", bus_addr, v.exp_baddr);
                        chk("bus_wr", 32'(bus_wr), 32'(v.wr));
                        if (v.wr) begin
                            chk("bus_wstrb", 32'(bus_wstrb), 32'(v.exp_wstrb));
                            chk("bus_wdata", bus_wdata, v.exp_wdata);
                        end
                    end
                    if (gcount == v.gnt_lat) begin
                        bus_gnt = 1'b1; granted = 1;
                        if (v.rv_lat == 0) begin
                            bus_rvalid = 1'b1; bus_rdata = v.rdata;
                        end
                    end
                    gcount++;
                end else if (granted) begin
                    since++;
                    if (since == v.rv_lat) begin
                        bus_rvalid = 1'b1; bus_rdata = v.rdata;
                    end
                end
                @(negedge clk);
            end
        end
        bus_gnt = 1'b0; bus_rvalid = 1'b0;
        if (!done) begin
            checks++; failures++;
            $display("FAIL op_complete: got no completion, required stall release within 60 cycles");
            void'(exp_q.pop_front());
        end else begin
            e = exp_q.pop_front();
            chk("readdataM", readdataM, e);
        end
    endtask

    initial begin
        int sc, rc, ec, extra_req;
        logic [31:0] e;
        vec_t v;

        rst = 1'b1; memenM = 1'b0; memwriteM = 1'b0; sizeM = SIZE_W; signedM = 1'b0;
        addrM = '0; writedataM = '0; stall_ext = 1'b0;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
        last_rd = '0;

        //            wr  size    sg addr          wdata         rdata         baddr         strb     ewdata        exp_rd        gl rl
        vecs[0] = mk(0, SIZE_W, 0, 32'h00000100, 32'h0,        32'hDEADBEEF, 32'h00000100, 4'b1111, 32'h0,        32'hDEADBEEF, 0, 1);
        vecs[1] = mk(0, SIZE_B, 1, 32'h00000103, 32'h0,        32'h80112233, 32'h00000100, 4'b1000, 32'h0,        32'hFFFFFF80, 0, 1);
        vecs[2] = mk(0, SIZE_B, 0, 32'h00000103, 32'h0,        32'h80112233, 32'h00000100, 4'b1000, 32'h0,        32'h00000080, 1, 2);
        vecs[3] = mk(1, SIZE_H, 0, 32'h00000202, 32'h00001234, 32'h0,        32'h00000200, 4'b1100, 32'h12341234, 32'h0,        0, 1);
        vecs[4] = mk(0, SIZE_H, 1, 32'h00000102, 32'h0,        32'h80011234, 32'h00000100, 4'b1100, 32'h0,        32'hFFFF8001, 2, 0);
        vecs[5] = mk(0, SIZE_H, 0, 32'h00000100, 32'h0,        32'h1234F00D, 32'h00000100, 4'b0011, 32'h0,        32'h0000F00D, 0, 0);
        vecs[6] = mk(1, SIZE_B, 0, 32'h00000301, 32'hFFFFFFA5, 32'h0,        32'h00000300, 4'b0010, 32'hA5A5A5A5, 32'h0,        1, 1);
        vecs[7] = mk(1, SIZE_W, 0, 32'h00000404, 32'hCAFEF00D, 32'h0,        32'h00000404, 4'b1111, 32'hCAFEF00D, 32'h0,        0, 3);
        vecs[8] = mk(0, SIZE_B, 1, 32'h00000101, 32'h0,        32'h00007F00, 32'h00000100, 4'b0010, 32'h0,        32'h0000007F, 0, 1);
        vecs[9] = mk(0, 2'b11,  0, 32'h00000010, 32'h0,        32'h12345678, 32'h00000010, 4'b1111, 32'h0,        32'h12345678, 1, 0);

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_bus_wr", 32'(bus_wr), 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        chk("rst_stall_mem", 32'(stall_mem), 32'd0);
        chk("rst_readdataM", readdataM, 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_wdata", bus_wdata, 32'd0);
        chk("rst_bus_wstrb", 32'(bus_wstrb), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Table of transactions
        for (int i = 0; i < 10; i++) begin
            e = vecs[i].wr ? last_rd : vecs[i].exp_rd;
            run_op(vecs[i], e, sc, rc, ec);
            memenM = 1'b0;
            last_rd = e;
            chk("stall_cycles", 32'(sc), 32'(2 + vecs[i].gnt_lat + vecs[i].rv_lat));
            chk("req_cycles", 32'(rc), 32'(vecs[i].gnt_lat + 1));
            chk("no_bus_err", 32'(ec), 32'd0);
        end

        // Misaligned ops: flagged, no request, no stall
        @(negedge clk);
        memenM = 1'b1; memwriteM = 1'b0; sizeM = SIZE_W; addrM = 32'h00000101;
        #1;
        chk("lw_adel", 32'(adel), 32'd1);
        chk("lw_ades", 32'(ades), 32'd0);
        chk("lw_mis_stall", 32'(stall_mem), 32'd0);
        @(negedge clk);
        #1;
        chk("lw_mis_req", 32'(bus_req), 32'd0);
        memwriteM = 1'b1; addrM = 32'h00000102;
        #1;
        chk("sw_ades", 32'(ades), 32'd1);
        chk("sw_adel", 32'(adel), 32'd0);
        chk("sw_mis_stall", 32'(stall_mem), 32'd0);
        memwriteM = 1'b0; sizeM = SIZE_H; addrM = 32'h00000103;
        #1;
        chk("lh_adel", 32'(adel), 32'd1);
        @(negedge clk);
        #1;
        chk("mis_req_after", 32'(bus_req), 32'd0);
        memenM = 1'b0;

        // Timeout: grant never comes
        v = mk(0, SIZE_W, 0, 32'h00000500, 32'h0, 32'h0, 32'h00000500, 4'b1111, 32'h0, 32'h0, 1000, 0);
        run_op(v, 32'h0, sc, rc, ec);
        memenM = 1'b0;
        last_rd = 32'h0;
        chk("to_req_cycles", 32'(rc), 32'd4);
        chk("to_stall_cycles", 32'(sc), 32'd5);
        chk("to_err_pulses", 32'(ec), 32'd1);
        @(negedge clk);
        #1;
        chk("to_err_cleared", 32'(bus_err), 32'd0);
        chk("to_req_low", 32'(bus_req), 32'd0);

        // External stall held in DONE: op must not be reissued
        stall_ext = 1'b1;
        v = mk(0, SIZE_W, 0, 32'h00000600, 32'h0, 32'h0BADF00D, 32'h00000600, 4'b1111, 32'h0, 32'h0BADF00D, 0, 1);
        run_op(v, 32'h0BADF00D, sc, rc, ec);
        extra_req = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            if (bus_req) extra_req++;
            chk("sx_stall_mem", 32'(stall_mem), 32'd0);
        end
        chk("sx_one_txn", 32'(rc + extra_req), 32'd1);
        chk("sx_readdata", readdataM, 32'h0BADF00D);
        stall_ext = 1'b0;
        memenM = 1'b0;
        @(negedge clk);
        #1;
        chk("sx_idle_no_req", 32'(bus_req), 32'd0);

        // Async reset while waiting for the response
        @(negedge clk);
        memenM = 1'b1; memwriteM = 1'b0; sizeM = SIZE_W; addrM = 32'h00000700;
        @(negedge clk);
        #1;
        chk("rw_req", 32'(bus_req), 32'd1);
        bus_gnt = 1'b1;
        @(negedge clk);
        bus_gnt = 1'b0;
        #1;
        chk("rw_wait_req", 32'(bus_req), 32'd0);
        chk("rw_wait_stall", 32'(stall_mem), 32'd1);
        memenM = 1'b0;
        rst = 1'b1;
        #1;
        chk("rw_rst_req", 32'(bus_req), 32'd0);
        chk("rw_rst_state", 32'(dut.state), 32'(IDLE));
        chk("rw_rst_stall", 32'(stall_mem), 32'd0);
        chk("rw_rst_addr", bus_addr, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus_rvalid = 1'b1; bus_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        bus_rvalid = 1'b0;
        #1;
        chk("rw_late_rd", readdataM, 32'd0);
        chk("rw_late_stall", 32'(stall_mem), 32'd0);
        chk("rw_late_req", 32'(bus_req), 32'd0);

        // Normal operation after the reset
        run_op(vecs[0], vecs[0].exp_rd, sc, rc, ec);
        memenM = 1'b0;
        chk("post_stall_cycles", 32'(sc), 32'd3);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
